rc4_stream_decrypt: RTL and testbench

//  Consumer end of the RC4 keystream buffer. Reads the keystream nibbles that the RC4 core
//  has written, packs them into 32-bit words and XORs them with incoming ciphertext words.

---
 rtl/rc4_dec_pkg.sv | 22 ++
 rtl/rc4_ks_word_assembler.sv | 65 ++++++
 rtl/rc4_stream_decrypt.sv | 157 +++++++++++++++
 tb/tb_rc4_stream_decrypt.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_dec_pkg.sv
// Shared types and sizing constants for the RC4 keystream decrypt path.
// Build option: RC4_DEC_KS_WRAP_EN (see rc4_stream_decrypt.sv).
package rc4_dec_pkg;

  localparam int RC4_NIB_W    = 4;
  localparam int RC4_WORD_W   = 32;
  localparam int RC4_KS_DEPTH = 16;
  localparam int RC4_ADDR_W   = 4;

  localparam int NIBS_PER_WORD = RC4_WORD_W / RC4_NIB_W;
  // One extra cycle because the keystream buffer read is registered.
  localparam int FETCH_CYCLES  = NIBS_PER_WORD + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_CT,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_ks_word_assembler.sv
// Keystream word assembler: walks the buffer address from base and packs the
// returned nibbles MSB-first into one word. start is held high for the whole
// fetch; done is high in the last fetch cycle, when the final nibble lands.
module rc4_ks_word_assembler
  import rc4_dec_pkg::*;
#(
  parameter int NIB_W   = RC4_NIB_W,
  parameter int WORD_W  = RC4_WORD_W,
  parameter int ADDR_W  = RC4_ADDR_W,
  parameter int NPW     = NIBS_PER_WORD,
  parameter int FETCH_N = FETCH_CYCLES
) (
  input  logic              clk,
  input  logic              reset_1,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] ks_addr,
  input  logic [NIB_W-1:0]  ks_data,
  output logic              done,
  output logic [WORD_W-1:0] ks_word
);

  localparam int CNT_W = $clog2(FETCH_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FETCH_N - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] shifted;

  // Word shifted up by one nibble lane with the fresh nibble at the bottom,
  // so the first nibble fetched ends up in the top lane after NPW shifts.
  assign shifted[NIB_W-1:0] = ks_data;
  for (genvar gi = 1; gi < NPW; gi++) begin : g_lane
    assign shifted[gi*NIB_W +: NIB_W] = word_q[(gi-1)*NIB_W +: NIB_W];
  end

  // Count fetch cycles and shift in the nibble addressed on the previous cycle.
  always_comb begin
    cnt_d  = '0;
    word_d = word_q;
    if (start) begin
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_q != '0) begin
        word_d = shifted;
      end
    end
  end

  // Counter and packed-word registers.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // The last fetch cycle only captures, so the address parks back on base.
  assign ks_addr = base + ((cnt_q == LAST) ? '0 : ADDR_W'(cnt_q));
  assign done    = start && (cnt_q == LAST);
  assign ks_word = word_q;

endmodule

// File: rtl/rc4_stream_decrypt.sv
// RC4 keystream consumer: fetches one keystream word per ciphertext word,
// XORs it in and hands plaintext downstream over valid/ready.
// Build option: define RC4_DEC_KS_WRAP_EN to wrap back to the start of the
// keystream buffer instead of stopping (keystream reuse, test use only).
module rc4_stream_decrypt
  import rc4_dec_pkg::*;
#(
  parameter int NIB_W    = RC4_NIB_W,
  parameter int WORD_W   = RC4_WORD_W,
  parameter int KS_DEPTH = RC4_KS_DEPTH,
  parameter int ADDR_W   = RC4_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_1,
  input  logic              ks_ready,
  output logic [ADDR_W-1:0] ks_addr,
  input  logic [NIB_W-1:0]  ks_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [WORD_W-1:0] ct_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [WORD_W-1:0] pt_data,
  output logic              ks_exhausted
);

  localparam int NPW = WORD_W / NIB_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              pt_valid_q, pt_valid_d;
  logic [WORD_W-1:0] pt_data_q, pt_data_d;
  logic              exh_q, exh_d;

  logic              fetch_done;
  logic [WORD_W-1:0] ks_word;
  logic [ADDR_W:0]   next_base_ext;
  logic              end_of_buf;

  rc4_ks_word_assembler #(
    .NIB_W   (NIB_W),
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .NPW     (NPW),
    .FETCH_N (NPW + 1)
  ) u_asm (
    .clk     (clk),
    .reset_1 (reset_1),
    .start   (state_q == FETCH),
    .base    (base_q),
    .ks_addr (ks_addr),
    .ks_data (ks_data),
    .done    (fetch_done),
    .ks_word (ks_word)
  );

  // One bit wider than the address so running off the end is visible.
  assign next_base_ext = {1'b0, base_q} + (ADDR_W+1)'(NPW);
  assign end_of_buf    = (next_base_ext >= (ADDR_W+1)'(KS_DEPTH));

  // Next-state, handshake and plaintext capture.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    exh_d      = 1'b0;
    ct_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        base_d = '0;
        if (ks_ready) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!ks_ready) begin
          state_d = IDLE;
          base_d  = '0;
        end else if (fetch_done) begin
          state_d = WAIT_CT;
        end
      end
      WAIT_CT: begin
        if (!ks_ready) begin
          state_d = IDLE;
          base_d  = '0;
        end else begin
          // Gated by ks_ready so a word is never accepted on the way out.
          ct_ready = 1'b1;
          if (ct_valid) begin
            pt_data_d  = ct_data ^ ks_word;
            pt_valid_d = 1'b1;
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        // A pending word always completes, even if ks_ready has dropped.
        if (pt_ready) begin
          pt_valid_d = 1'b0;
          if (!ks_ready) begin
            state_d = IDLE;
            base_d  = '0;
          end else if (!end_of_buf) begin
            base_d  = next_base_ext[ADDR_W-1:0];
            state_d = FETCH;
          end else begin
`ifdef RC4_DEC_KS_WRAP_EN
            base_d  = '0;
            state_d = FETCH;
            exh_d   = 1'b1;
`else
            base_d  = next_base_ext[ADDR_W-1:0];
            state_d = DONE;
            exh_d   = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        if (!ks_ready) begin
          state_d = IDLE;
          base_d  = '0;
        end else begin
          exh_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        base_d  = '0;
      end
    endcase
  end

  // State, base pointer and output registers.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state_q    <= IDLE;
      base_q     <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      exh_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
      exh_q      <= exh_d;
    end
  end

  assign pt_valid     = pt_valid_q;
  assign pt_data      = pt_data_q;
  assign ks_exhausted = exh_q;

endmodule

// File: tb/tb_rc4_stream_decrypt.sv
// Self-checking bench for rc4_stream_decrypt. Keystream buffer entry i holds i.
// Build option RC4_DEC_KS_WRAP_EN selects the wrap-around expectations.
`timescale 1ns/1ps
module tb_rc4_stream_decrypt;

  logic        clk = 1'b0;
  logic        reset_1 = 1'b0;
  logic        ks_ready = 1'b0;
  logic [3:0]  ks_addr;
  logic [3:0]  ks_data = 4'h0;
  logic        ct_valid = 1'b0;
  logic        ct_ready;
  logic [31:0] ct_data = 32'h0;
  logic        pt_valid;
  logic        pt_ready = 1'b1;
  logic [31:0] pt_data;
  logic        ks_exhausted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  ks_mem [16];
  logic [31:0] exp_q [$];
  int          widx = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;

  always #5 clk = ~clk;

  rc4_stream_decrypt dut (
    .clk          (clk),
    .reset_1      (reset_1),
    .ks_ready     (ks_ready),
    .ks_addr      (ks_addr),
    .ks_data      (ks_data),
    .ct_valid     (ct_valid),
    .ct_ready     (ct_ready),
    .ct_data      (ct_data),
    .pt_valid     (pt_valid),
    .pt_ready     (pt_ready),
    .pt_data      (pt_data),
    .ks_exhausted (ks_exhausted)
  );

  initial begin
    for (int i = 0; i < 16; i++) ks_mem[i] = 4'(i);
  end

  // Keystream buffer with registered read.
  always @(posedge clk) ks_data <= ks_mem[ks_addr];

  // Keystream word for the idx-th word decrypted since (re)start.
  function automatic logic [31:0] key_word(int idx);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 8; j++) w = {w[27:0], ks_mem[(8*idx + j) % 16]};
    return w;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    widx = 0;
  endtask

  // Scoreboard: predicts each plaintext at ciphertext acceptance, checks each
  // delivered plaintext, and checks hold/exclusivity rules every cycle.
  always @(negedge clk) begin
    if (reset_1) begin
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pt_unexpected: got 0x%08h, want no output at %0t", pt_data, $time);
        end else begin
          check("pt_stream", pt_data, exp_q.pop_front());
          widx++;
        end
      end
      if (ct_valid && ct_ready) begin
        exp_q.push_back(ct_data ^ key_word(widx));
        $display("[TB] ct accepted 0x%08h (word %0d)", ct_data, widx);
      end
      if (prev_stall) begin
        check("pt_hold_valid", pt_valid, 1);
        check("pt_hold_data", pt_data, prev_data);
      end
      check("ct_ready_vs_pt_valid", ct_ready && pt_valid, 0);
      check("ct_ready_vs_exhausted", ct_ready && ks_exhausted, 0);
    end
    prev_stall = reset_1 && pt_valid && !pt_ready;
    prev_data  = pt_data;
  end

  // Entry: the next posedge is the one that takes the DUT into FETCH.
  task automatic run_word(input logic [31:0] ct, input logic [31:0] exp_pt,
                          input int base, input bit hold, input bit exh0);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      if (k == 0) begin
        #1;
        ct_valid = 1'b1;
        ct_data  = ct;
        if (hold) pt_ready = 1'b0;
      end
      @(negedge clk);
      if (k < 8) check("ks_addr_seq", ks_addr, 32'((base + k) % 16));
      check("ct_ready_during_fetch", ct_ready, 0);
      check("ks_exhausted_fetch", ks_exhausted, (k == 0) ? exh0 : 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    check("ct_ready_rise_9", ct_ready, 1);
    @(posedge clk);
    #1 ct_valid = 1'b0;
    @(negedge clk);
    check("pt_valid_latency", pt_valid, 1);
    check("pt_data_literal", pt_data, exp_pt);
    $display("[TB] word base %0d ct 0x%08h pt 0x%08h", base, ct, pt_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset held, then idle with ks_ready low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ks_addr", ks_addr, 0);
    check("rst_ct_ready", ct_ready, 0);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pt_data", pt_data, 0);
    check("rst_ks_exhausted", ks_exhausted, 0);
    @(posedge clk);
    #1 reset_1 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ks_addr", ks_addr, 0);
      check("idle_ct_ready", ct_ready, 0);
      check("idle_pt_valid", pt_valid, 0);
      check("idle_ks_exhausted", ks_exhausted, 0);
    end
    check("model_word0", key_word(0), 32'h01234567);
    check("model_word1", key_word(1), 32'h89ABCDEF);
    check("model_word2", key_word(2), 32'h01234567);

    // 2. First word, 3. second word.
    @(posedge clk);
    #1 ks_ready = 1'b1;
    run_word(32'h4AE65B9E, 32'h4BC51EF9, 0, 1'b0, 1'b0);
    run_word(32'hC26ED316, 32'h4BC51EF9, 8, 1'b0, 1'b0);
`ifdef RC4_DEC_KS_WRAP_EN
    run_word(32'h12345678, 32'h1317131F, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1 ks_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wrap_drop_ct_ready", ct_ready, 0);
    check("wrap_drop_ks_exhausted", ks_exhausted, 0);
`else
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      if (c == 0) begin
        #1;
        ct_valid = 1'b1;
        ct_data  = 32'h13579BDF;
      end
      @(negedge clk);
      check("done_ks_exhausted", ks_exhausted, 1);
      check("done_ct_ready", ct_ready, 0);
      check("done_pt_valid", pt_valid, 0);
    end
    @(posedge clk);
    #1;
    ct_valid = 1'b0;
    ks_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_exit_ks_exhausted", ks_exhausted, 0);
`endif
    model_reset();

    // 4. Downstream stall for 5 cycles.
    @(posedge clk);
    #1 ks_ready = 1'b1;
    run_word(32'hFFFFFFFF, 32'hFEDCBA98, 0, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_pt_valid", pt_valid, 1);
      check("stall_pt_data", pt_data, 32'hFEDCBA98);
      check("stall_ct_ready", ct_ready, 0);
      check("stall_ks_addr", ks_addr, 0);
    end
    @(posedge clk);
    #1 pt_ready = 1'b1;

    // 5. ks_ready dropped mid-fetch, then restarted from address 0.
    repeat (3) @(posedge clk);
    #1 ks_ready = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_pt_valid", pt_valid, 0);
      check("abort_ct_ready", ct_ready, 0);
    end
    check("abort_ks_addr", ks_addr, 0);
    model_reset();
    @(posedge clk);
    #1 ks_ready = 1'b1;
    run_word(32'h00000000, 32'h01234567, 0, 1'b1, 1'b0);

    // 6. Asynchronous reset while a word is pending.
    #2 reset_1 = 1'b0;
    #1;
    check("async_rst_pt_valid", pt_valid, 0);
    check("async_rst_pt_data", pt_data, 0);
    check("async_rst_ct_ready", ct_ready, 0);
    check("async_rst_ks_addr", ks_addr, 0);
    model_reset();
    ks_ready = 1'b0;
    pt_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_1 = 1'b1;
    @(posedge clk);
    #1 ks_ready = 1'b1;
    run_word(32'hA5A5A5A5, 32'hA486E0C2, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
